// File: rtl/ila_cmd_pkg.sv
// ila_cmd_pkg: constants shared by the ILA command controller and the capture
// engine.
//   SYNC_BYTE     packet start marker
//   OPC_*         command opcodes carried in the second packet byte
//   state_t       command framer FSM state encoding
//   calc_chk()    packet checksum, used when ILA_CMD_CHECKSUM_EN is defined
package ila_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;

  localparam logic [7:0] OPC_TRIG_VAL  = 8'h01;
  localparam logic [7:0] OPC_TRIG_MASK = 8'h02;
  localparam logic [7:0] OPC_DEPTH     = 8'h03;
  localparam logic [7:0] OPC_ARM       = 8'h10;
  localparam logic [7:0] OPC_DISARM    = 8'h11;

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_OPC  = 3'd1,
    S_D0   = 3'd2,
    S_D1   = 3'd3,
    S_CHK  = 3'd4,
    S_EXEC = 3'd5
  } state_t;

  // XOR of the opcode and both data bytes; the sender appends this as CHK.
  function automatic logic [7:0] calc_chk(input logic [7:0] opc,
                                          input logic [7:0] d0,
                                          input logic [7:0] d1);
    return opc ^ d0 ^ d1;
  endfunction

endpackage

// File: rtl/ila_cmd_ctrl.sv
// ila_cmd_ctrl: frames the UART byte stream into fixed-length command packets
// (SYNC, OPC, D0, D1 [, CHK]) and drives the logic analyzer's trigger/capture
// configuration registers plus arm/disarm pulses.
//
// Optional feature: define ILA_CMD_CHECKSUM_EN to add a fifth checksum byte
// (CHK = OPC ^ D0 ^ D1); a mismatch rejects the packet.
//
// Ports:
//   i_sys_clk     system clock, rising edge
//   i_rst         synchronous active-high reset
//   i_rx_dv       one-cycle strobe, i_rx_byte valid
//   i_rx_byte     received byte
//   o_trig_value  trigger compare value            (reset 0)
//   o_trig_mask   trigger compare mask, 1=compare  (reset 0)
//   o_depth       post-trigger sample count        (reset DEPTH_RST)
//   o_arm         one-cycle arm pulse
//   o_disarm      one-cycle disarm pulse
//   o_cmd_err     one-cycle pulse on a rejected or abandoned packet
//   o_busy        high while a packet is being framed or executed
module ila_cmd_ctrl
  import ila_cmd_pkg::*;
#(
  parameter int          IDLE_TIMEOUT = 8680,
  parameter logic [15:0] DEPTH_RST    = 16'd1024
) (
  input  logic        i_sys_clk,
  input  logic        i_rst,
  input  logic        i_rx_dv,
  input  logic [7:0]  i_rx_byte,
  output logic [15:0] o_trig_value,
  output logic [15:0] o_trig_mask,
  output logic [15:0] o_depth,
  output logic        o_arm,
  output logic        o_disarm,
  output logic        o_cmd_err,
  output logic        o_busy
);

  localparam int              CNT_W    = $clog2(IDLE_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_TIMEOUT - 1);

  state_t           state_r;
  logic             dv_r;
  logic [7:0]       byte_r;
  logic [7:0]       opc_r;
  logic [7:0]       d0_r;
  logic [7:0]       d1_r;
  logic [CNT_W-1:0] idle_cnt_r;
  logic [15:0]      trig_value_r;
  logic [15:0]      trig_mask_r;
  logic [15:0]      depth_r;
  logic             arm_r;
  logic             disarm_r;
  logic             err_r;
  logic             busy_r;
`ifdef ILA_CMD_CHECKSUM_EN
  logic             chk_ok_r;
`endif

  logic             pkt_open_s;
  logic             sync_accept_s;
  logic             timeout_s;
  logic             exec_ok_s;
  logic [15:0]      data_s;

  // Input stage: the FSM acts on the byte one cycle after it is sampled, so a
  // packet's final byte puts the FSM in S_EXEC one edge after its strobe.
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      dv_r   <= 1'b0;
      byte_r <= 8'h00;
    end else begin
      dv_r   <= i_rx_dv;
      byte_r <= i_rx_byte;
    end
  end

  // Packet-state decode and inter-byte timeout detection.
  always_comb begin
    pkt_open_s    = 1'b0;
    sync_accept_s = 1'b0;
    timeout_s     = 1'b0;
    case (state_r)
      S_OPC, S_D0, S_D1, S_CHK: pkt_open_s = 1'b1;
      default:                  pkt_open_s = 1'b0;
    endcase
    if ((state_r == S_SYNC) && dv_r && (byte_r == SYNC_BYTE)) begin
      sync_accept_s = 1'b1;
    end else begin
      sync_accept_s = 1'b0;
    end
    // A byte strobing in the same cycle as the expiry wins over the timeout.
    if (pkt_open_s && !dv_r && !i_rx_dv && (idle_cnt_r == CNT_LAST)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Command validity: opcode known, depth nonzero, and checksum (if built in).
  always_comb begin
    data_s    = {d1_r, d0_r};
    exec_ok_s = 1'b0;
    case (opc_r)
      OPC_TRIG_VAL, OPC_TRIG_MASK, OPC_ARM, OPC_DISARM: exec_ok_s = 1'b1;
      OPC_DEPTH: exec_ok_s = (data_s != 16'h0000);
      default:   exec_ok_s = 1'b0;
    endcase
`ifdef ILA_CMD_CHECKSUM_EN
    exec_ok_s = exec_ok_s & chk_ok_r;
`endif
  end

  // Idle counter: cycles since the last raw strobe while a packet is open.
  // It also runs on the edge that accepts SYNC, since that byte's strobe
  // already cleared it one cycle earlier.
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      idle_cnt_r <= '0;
    end else if (i_rx_dv || timeout_s) begin
      idle_cnt_r <= '0;
    end else if (pkt_open_s || sync_accept_s) begin
      idle_cnt_r <= idle_cnt_r + CNT_W'(1);
    end else begin
      idle_cnt_r <= '0;
    end
  end

  // Framing FSM with registered configuration outputs and pulses.
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      state_r      <= S_SYNC;
      opc_r        <= 8'h00;
      d0_r         <= 8'h00;
      d1_r         <= 8'h00;
      trig_value_r <= 16'h0000;
      trig_mask_r  <= 16'h0000;
      depth_r      <= DEPTH_RST;
      arm_r        <= 1'b0;
      disarm_r     <= 1'b0;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
`ifdef ILA_CMD_CHECKSUM_EN
      chk_ok_r     <= 1'b0;
`endif
    end else begin
      arm_r    <= 1'b0;
      disarm_r <= 1'b0;
      err_r    <= 1'b0;
      if (timeout_s) begin
        state_r <= S_SYNC;
        busy_r  <= 1'b0;
        err_r   <= 1'b1;
      end else begin
        case (state_r)
          S_SYNC: begin
            // Non-SYNC bytes are dropped silently while hunting.
            if (sync_accept_s) begin
              state_r <= S_OPC;
              busy_r  <= 1'b1;
            end
          end
          S_OPC: begin
            if (dv_r) begin
              opc_r   <= byte_r;
              state_r <= S_D0;
            end
          end
          S_D0: begin
            if (dv_r) begin
              d0_r    <= byte_r;
              state_r <= S_D1;
            end
          end
          S_D1: begin
            if (dv_r) begin
              d1_r    <= byte_r;
`ifdef ILA_CMD_CHECKSUM_EN
              state_r <= S_CHK;
`else
              state_r <= S_EXEC;
`endif
            end
          end
`ifdef ILA_CMD_CHECKSUM_EN
          S_CHK: begin
            if (dv_r) begin
              chk_ok_r <= (byte_r == calc_chk(opc_r, d0_r, d1_r));
              state_r  <= S_EXEC;
            end
          end
`endif
          S_EXEC: begin
            // Any strobe seen here is ignored; the packet is applied once.
            if (exec_ok_s) begin
              case (opc_r)
                OPC_TRIG_VAL:  trig_value_r <= data_s;
                OPC_TRIG_MASK: trig_mask_r  <= data_s;
                OPC_DEPTH:     depth_r      <= data_s;
                OPC_ARM:       arm_r        <= 1'b1;
                OPC_DISARM:    disarm_r     <= 1'b1;
                default:       err_r        <= 1'b1;
              endcase
            end else begin
              err_r <= 1'b1;
            end
            state_r <= S_SYNC;
            busy_r  <= 1'b0;
          end
          default: begin
            state_r <= S_SYNC;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_trig_value = trig_value_r;
  assign o_trig_mask  = trig_mask_r;
  assign o_depth      = depth_r;
  assign o_arm        = arm_r;
  assign o_disarm     = disarm_r;
  assign o_cmd_err    = err_r;
  assign o_busy       = busy_r;

endmodule

// File: tb/tb_ila_cmd_ctrl.sv
// Self-checking bench for ila_cmd_ctrl: directed packets with hand-computed
// expectations, then randomized traffic compared every cycle against a
// packet-level reference model (byte queue + timestamps).
module tb_ila_cmd_ctrl;

  localparam int T = 24;
`ifdef ILA_CMD_CHECKSUM_EN
  localparam int PKT_LEN = 5;
`else
  localparam int PKT_LEN = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic [15:0] o_trig_value, o_trig_mask, o_depth;
  logic        o_arm, o_disarm, o_cmd_err, o_busy;

  int checks = 0;
  int errors = 0;

  ila_cmd_ctrl #(.IDLE_TIMEOUT(T), .DEPTH_RST(16'd1024)) dut (
    .i_sys_clk(clk), .i_rst(rst), .i_rx_dv(dv), .i_rx_byte(rx_byte),
    .o_trig_value(o_trig_value), .o_trig_mask(o_trig_mask), .o_depth(o_depth),
    .o_arm(o_arm), .o_disarm(o_disarm), .o_cmd_err(o_cmd_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_value = 0, m_mask = 0, m_depth = 16'd1024;
  logic        m_arm = 0, m_disarm = 0, m_err = 0, m_busy = 0;
  logic [7:0]  pkt[$];
  bit          m_exec = 0;
  bit          prev_dv = 0;
  logic [7:0]  prev_byte = 0;
  int          cyc = 0;
  int          last_raw = 0;
  bit          started = 0;

  always @(posedge clk) begin
    cyc++;
    started = 1;
    m_arm = 0; m_disarm = 0; m_err = 0;
    if (rst) begin
      m_value = 0; m_mask = 0; m_depth = 16'd1024; m_busy = 0;
      pkt.delete(); m_exec = 0; prev_dv = 0;
    end else begin
      if (dv) last_raw = cyc;
      if (m_exec) begin
        logic [7:0]  opc;
        logic [15:0] data;
        bit          ok;
        opc  = pkt[1];
        data = {pkt[3], pkt[2]};
        ok   = (opc == 8'h01) || (opc == 8'h02) || (opc == 8'h10) || (opc == 8'h11) ||
               ((opc == 8'h03) && (data != 0));
`ifdef ILA_CMD_CHECKSUM_EN
        if (pkt[4] != (pkt[1] ^ pkt[2] ^ pkt[3])) ok = 0;
`endif
        if (!ok) m_err = 1;
        else if (opc == 8'h01) m_value = data;
        else if (opc == 8'h02) m_mask = data;
        else if (opc == 8'h03) m_depth = data;
        else if (opc == 8'h10) m_arm = 1;
        else m_disarm = 1;
        m_exec = 0;
        pkt.delete();
      end else if (pkt.size() == 0) begin
        if (prev_dv && prev_byte == 8'hA5) pkt.push_back(prev_byte);
      end else if (prev_dv) begin
        pkt.push_back(prev_byte);
        if (pkt.size() == PKT_LEN) m_exec = 1;
      end else if (cyc - last_raw == T) begin
        m_err = 1;
        pkt.delete();
      end
      m_busy = (pkt.size() != 0);
      prev_dv = dv;
      prev_byte = rx_byte;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      check("trig_value", o_trig_value, m_value);
      check("trig_mask", o_trig_mask, m_mask);
      check("depth", o_depth, m_depth);
      check("arm", {15'd0, o_arm}, {15'd0, m_arm});
      check("disarm", {15'd0, o_disarm}, {15'd0, m_disarm});
      check("cmd_err", {15'd0, o_cmd_err}, {15'd0, m_err});
      check("busy", {15'd0, o_busy}, {15'd0, m_busy});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    dv = 1'b1;
    rx_byte = b;
    tick();
    dv = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_pkt(input logic [7:0] opc, input logic [15:0] data,
                          input int gap, input bit bad);
    logic [7:0] chk;
    chk = opc ^ data[7:0] ^ data[15:8];
    if (bad) chk = chk ^ 8'h5A;
    send(8'hA5, gap);
    send(opc, gap);
    send(data[7:0], gap);
`ifdef ILA_CMD_CHECKSUM_EN
    send(data[15:8], gap);
    send(chk, 0);
`else
    send(data[15:8], 0);
`endif
  endtask

  task automatic watch(input int n, output int arms, output int disarms, output int errs);
    arms = 0; disarms = 0; errs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      arms += int'(o_arm);
      disarms += int'(o_disarm);
      errs += int'(o_cmd_err);
    end
    tick();
  endtask

  function automatic int pick_gap();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return T - 1;
    if (r == 1) return T;
    return $urandom_range(0, 2);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int a, d, e, k;
    bit seen;
    repeat (3) tick();
    @(negedge clk);
    check("rst_value", o_trig_value, 16'h0000);
    check("rst_mask", o_trig_mask, 16'h0000);
    check("rst_depth", o_depth, 16'd1024);
    check("rst_busy", {15'd0, o_busy}, 16'h0000);
    rst = 1'b0;
    tick();

    // Abandoned packet: error exactly T cycles after the second byte.
    send(8'hA5, 0);
    send(8'h01, 0);
    seen = 0;
    for (k = 1; k <= T + 10; k++) begin
      @(negedge clk);
      if (o_cmd_err) begin
        seen = 1;
        break;
      end
    end
    check("timeout_latency", 16'(k - 1), 16'(T));
    check("timeout_busy", {15'd0, o_busy}, 16'h0000);
    check("timeout_value", o_trig_value, 16'h0000);
    tick();

    // Trigger value write, visible two edges after the final byte's edge.
    send_pkt(8'h01, 16'h1234, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("tv_not_yet", o_trig_value, 16'h0000);
    @(negedge clk);
    check("tv_written", o_trig_value, 16'h1234);
    tick();

    send_pkt(8'h10, 16'h0000, 1, 0);
    watch(6, a, d, e);
    check("arm_once", 16'(a), 16'd1);
    check("arm_no_err", 16'(e), 16'd0);
    check("arm_value_kept", o_trig_value, 16'h1234);
    check("arm_depth_kept", o_depth, 16'd1024);

    send_pkt(8'h7F, 16'h0000, 0, 0);
    watch(6, a, d, e);
    check("badopc_err", 16'(e), 16'd1);
    check("badopc_depth", o_depth, 16'd1024);
    send_pkt(8'h03, 16'h0800, 2, 0);
    watch(6, a, d, e);
    check("depth_written", o_depth, 16'h0800);

    send(8'h00, 1);
    send(8'hFF, 1);
    send_pkt(8'h02, 16'h0FF0, 1, 0);
    watch(6, a, d, e);
    check("garbage_no_err", 16'(e), 16'd0);
    check("mask_written", o_trig_mask, 16'h0FF0);

    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h55, 0);
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("midrst_value", o_trig_value, 16'h0000);
    check("midrst_mask", o_trig_mask, 16'h0000);
    check("midrst_depth", o_depth, 16'd1024);
    check("midrst_busy", {15'd0, o_busy}, 16'h0000);
    rst = 1'b0;
    tick();
    send_pkt(8'h03, 16'h0000, 0, 0);
    watch(6, a, d, e);
    check("depth0_err", 16'(e), 16'd1);
    check("depth0_kept", o_depth, 16'd1024);
`ifdef ILA_CMD_CHECKSUM_EN
    send_pkt(8'h01, 16'h2211, 0, 1);
    watch(6, a, d, e);
    check("badchk_err", 16'(e), 16'd1);
    check("badchk_value", o_trig_value, 16'h0000);
`endif

    // Randomized traffic, checked by the model every cycle.
    for (int it = 0; it < 200; it++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        send(8'($urandom), $urandom_range(0, 2));
      end else if (kind == 1) begin
        int n;
        n = $urandom_range(0, 2);
        send(8'hA5, $urandom_range(0, 2));
        for (int j = 0; j < n; j++) send(8'($urandom), $urandom_range(0, 2));
        repeat (T + 2) tick();
      end else if (kind == 2) begin
        send(8'hA5, 0);
        send(8'($urandom), 0);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
      end else begin
        logic [7:0]  opc;
        logic [15:0] data;
        int          sel;
        sel = $urandom_range(0, 5);
        case (sel)
          0: opc = 8'h01;
          1: opc = 8'h02;
          2: opc = 8'h03;
          3: opc = 8'h10;
          4: opc = 8'h11;
          default: opc = 8'($urandom);
        endcase
        data = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
        send_pkt(opc, data, pick_gap(), ($urandom_range(0, 7) == 0));
        repeat ($urandom_range(0, 3)) tick();
      end
    end
    repeat (T + 5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ila_cmd_ctrl.md
# ila_cmd_ctrl

- Receives the byte stream produced by the UART receiver and frames it into fixed-length command packets.
- Decodes each packet and drives the logic analyzer's trigger and capture configuration registers, plus arm/disarm pulses.
- Sits between the UART receiver's data-valid/byte outputs and the capture engine. It is the only writer of capture configuration.

## Interface
Parameters:
- IDLE_TIMEOUT, 8680: clocks allowed between bytes of one packet before the packet is abandoned (20 bit-times at 434 clocks/bit). Minimum 2.
- DEPTH_RST, 1024: reset value of o_depth.

Ports:
- i_sys_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_rx_dv  in  1  one-cycle strobe; i_rx_byte valid this cycle.
- i_rx_byte  in  8  received byte.
- o_trig_value  out  16  trigger compare value; reset 0.
- o_trig_mask  out  16  trigger compare mask, 1 = bit compared; reset 0.
- o_depth  out  16  post-trigger sample count; reset DEPTH_RST.
- o_arm  out  1  one-cycle arm pulse; reset 0.
- o_disarm  out  1  one-cycle disarm pulse; reset 0.
- o_cmd_err  out  1  one-cycle pulse on a rejected packet; reset 0.
- o_busy  out  1  high whenever the FSM is not in S_SYNC; reset 0.

## Operation
**Packet format:** SYNC (0xA5), OPC, D0 (data LSB), D1 (data MSB), then CHK if the checksum feature is compiled in. Data = {D1, D0}.

**Opcodes:**
- 0x01: o_trig_value <= data.
- 0x02: o_trig_mask <= data.
- 0x03: o_depth <= data. A data value of 0 is rejected as an error.
- 0x10: pulse o_arm; data ignored.
- 0x11: pulse o_disarm; data ignored.
- Any other opcode: error.

**FSM states:** S_SYNC, S_OPC, S_D0, S_D1, S_CHK, S_EXEC. Transitions:
- S_SYNC: byte 0xA5 -> S_OPC. Any other byte is discarded silently, with no error.
- S_OPC -> S_D0 -> S_D1: each advance happens on i_rx_dv. The FSM latches OPC, D0 and D1 as they arrive.
- S_D1 on dv -> S_CHK if the checksum feature is enabled, otherwise -> S_EXEC.
- S_CHK on dv -> S_EXEC. The FSM latches a checksum-ok flag.
- S_EXEC: lasts exactly one cycle, then -> S_SYNC. It applies the register write or pulse, or pulses o_cmd_err if the opcode is invalid, depth is 0, or the checksum is bad. A rejected packet leaves all registers unchanged.

**Inter-byte timeout:**
- The counter clears on every i_rx_dv and in S_SYNC, and increments in S_OPC through S_CHK.
- When the count reaches IDLE_TIMEOUT-1: go to S_SYNC, pulse o_cmd_err, and discard the partial packet.

**Boundary cases:**
- Timeout and i_rx_dv in the same cycle: the byte wins and the counter clears.
- 0xA5 received mid-packet is treated as data, not as a resync.
- i_rx_dv asserted in S_EXEC is ignored. This cannot occur with a UART source at 4 or more clocks/bit.
- i_rst mid-packet: all registers return to their reset values, state returns to S_SYNC, and no pulse is emitted.

## Timing
- Final byte's i_rx_dv sampled at edge N: S_EXEC is registered at N+1.
- Register update, o_arm, o_disarm and o_cmd_err are visible after edge N+2.
- Each pulse is exactly one cycle wide. Configuration registers hold their value until the next valid write or reset.
- o_busy rises the cycle after the SYNC byte is accepted and falls when S_SYNC is re-entered.
- Timeout: o_cmd_err is asserted IDLE_TIMEOUT cycles after the last accepted byte's dv, and o_busy falls in the same cycle.
- Throughput: one packet per 4 bytes (5 with checksum). There are no stall or backpressure signals. The UART source cannot be throttled.

## Configuration
- Macro: ILA_CMD_CHECKSUM_EN.
- Defined: packets are 5 bytes, and state S_CHK exists. CHK must equal OPC ^ D0 ^ D1; on mismatch, S_EXEC pulses o_cmd_err with no write.
- Undefined: packets are 4 bytes. S_CHK and the checksum logic are absent, and D1 goes directly to S_EXEC.

## Structure
- Package ila_cmd_pkg holds:
  - SYNC_BYTE (8'hA5);
  - opcode constants OPC_TRIG_VAL, OPC_TRIG_MASK, OPC_DEPTH, OPC_ARM, OPC_DISARM;
  - the FSM state encoding.
- The capture engine imports the same package.
- No sub-module is needed: the design is a single FSM plus a timeout counter. The UART receiver is instantiated beside this block, not inside it.

## Test plan
- Send A5 01 34 12 (checksum enabled: add CHK 27): o_trig_value = 0x1234 at N+2; no o_cmd_err.
- Send A5 10 00 00 (checksum enabled: add CHK 10): o_arm high for exactly one cycle; o_trig_value, o_trig_mask and o_depth unchanged.
- Send A5 7F 00 00: o_cmd_err pulses once; all registers unchanged. A following A5 03 00 08 gives o_depth = 0x0800.
- Send 00 FF then A5 02 F0 0F: leading bytes ignored with no error; o_trig_mask = 0x0FF0.
- Send A5 01 then no further bytes: o_cmd_err and the fall of o_busy occur IDLE_TIMEOUT cycles after the second byte's dv; o_trig_value stays 0.
- Assert i_rst after A5 01 55; after release, send A5 03 00 00: all outputs at reset values after the reset, the depth-0 packet is rejected with o_cmd_err, and o_depth stays 1024. With checksum enabled, a bad CHK also gives o_cmd_err.
